// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Multi-port register file:
//   - one write port
//   - two independent registered read ports (A and B)
//   - read-only constants at the bottom of the index space
//   - a sequenced wipe engine that zeroes every writable register
//   - a combinational debug tap on one register
//
// Build option:
//   REGFILE_BYPASS_EN  When defined, a read of index i in the same cycle as an
//                      accepted write of i returns the write data
//                      (write-first). When undefined, that read returns the
//                      old stored value (read-first).
//
// Parameters:
//   WIDTH    data word width
//   AW       register select width (DEPTH = 2**AW)
//   NCONST   number of constant registers at indices 0..NCONST-1 (0..4)
//   DBG_SEL  register index driven onto dbg
//
// Ports:
//   clk                    clock, rising edge
//   clear                  asynchronous active-low reset
//   wr_en, wr_sel, wr_data write strobe, index and data
//   rd_en_a, rd_sel_a      port A read strobe and index
//   rd_data_a, rd_valid_a  port A registered data and one-cycle valid
//   rd_en_b, rd_sel_b      port B read strobe and index
//   rd_data_b, rd_valid_b  port B registered data and one-cycle valid
//   wipe_req               start a wipe of all writable registers
//   busy                   high while a wipe is in progress
//   dbg                    combinational copy of register DBG_SEL
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int WIDTH   = 16,
  parameter int AW      = 6,
  parameter int NCONST  = 4,
  parameter int DBG_SEL = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_sel_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_sel_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  input  logic             wipe_req,
  output logic             busy,
  output logic [WIDTH-1:0] dbg
);

  localparam int DEPTH = 2 ** AW;

  // First writable index; the wipe counter also starts here.
  localparam logic [AW-1:0] FIRST_RW = AW'(NCONST);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DBG_IDX  = AW'(DBG_SEL);

  typedef enum logic {
    IDLE,
    WIPE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    wipe_cnt;
  logic [WIDTH-1:0] regs [DEPTH];

  logic idle;
  logic wr_accept;
  logic fwd_a;
  logic fwd_b;

  // Reset contents: the constant pattern for the low indices, zero elsewhere.
  function automatic logic [WIDTH-1:0] reset_value(input int idx);
    logic [WIDTH-1:0] v;
    v = '0;
    if (idx < NCONST) begin
      case (idx)
        1:       v = WIDTH'(1);
        2:       v = {1'b1, {(WIDTH-1){1'b0}}};
        3:       v = '1;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Writes are accepted only when idle, and never to a constant index.
  always_comb begin
    idle      = (state == IDLE);
    wr_accept = idle && wr_en && (wr_sel >= FIRST_RW);
  end

  // Same-cycle forwarding. Only accepted writes can forward, so constant
  // indices never see forwarded data.
`ifdef REGFILE_BYPASS_EN
  assign fwd_a = wr_accept && (wr_sel == rd_sel_a);
  assign fwd_b = wr_accept && (wr_sel == rd_sel_b);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Wipe FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The final wipe cycle is the one that clears the top index.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (wipe_req) begin
          state_next = WIPE;
        end
      end
      WIPE: begin
        busy = 1'b1;
        if (wipe_cnt == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The wipe counter is reloaded on each accepted request. Because it is a
  // full-width counter, stepping past LAST_IDX wraps to zero, but the FSM
  // has already returned to IDLE by then.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wipe_cnt <= FIRST_RW;
    end else if (idle && wipe_req) begin
      wipe_cnt <= FIRST_RW;
    end else if (state == WIPE) begin
      wipe_cnt <= wipe_cnt + AW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Constants are written only by reset. A write accepted alongside a wipe
  // request still lands, because the FSM is still IDLE in that cycle.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= reset_value(i);
      end
    end else if (state == WIPE) begin
      regs[wipe_cnt] <= '0;
    end else if (wr_accept) begin
      regs[wr_sel] <= wr_data;
    end
  end

  assign dbg = regs[DBG_IDX];

  // ---------------------------------------------------------------------------
  // Read ports: each captures on its own strobe while idle. Otherwise the
  // data holds and valid drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
    end else if (idle && rd_en_a) begin
      rd_data_a  <= fwd_a ? wr_data : regs[rd_sel_a];
      rd_valid_a <= 1'b1;
    end else begin
      rd_valid_a <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rd_data_b  <= '0;
      rd_valid_b <= 1'b0;
    end else if (idle && rd_en_b) begin
      rd_data_b  <= fwd_b ? wr_data : regs[rd_sel_b];
      rd_valid_b <= 1'b1;
    end else begin
      rd_valid_b <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next-generation replacement for the single-port 64 x 16 file in the IDIOT datapath. It provides one write port and two independent registered read ports, hardwired constant registers at the bottom of the address space, and a sequenced bulk-wipe engine that replaces the zero-time combinational clear. It also provides a continuous debug tap on one register. It sits between decode (register selects) and the ALU/memory stage.

## Interface
- `WIDTH`, 16: data word width in bits.
- `AW`, 6: register select width; `DEPTH` = 2**`AW` (default 64).
- `NCONST`, 4: number of read-only constant registers at indices 0..`NCONST`-1 (legal range 0..4).
- `DBG_SEL`, 8: index driven onto `dbg`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clear`  in  1  reset; **asynchronous and active-low**.
- `wr_en`  in  1  write strobe.
- `wr_sel`  in  `AW`  write index.
- `wr_data`  in  `WIDTH`  write data.
- `rd_en_a`, `rd_en_b`  in  1  read strobes, ports A and B.
- `rd_sel_a`, `rd_sel_b`  in  `AW`  read indices.
- `rd_data_a`, `rd_data_b`  out  `WIDTH`  registered read data.
- `rd_valid_a`, `rd_valid_b`  out  1  one-cycle pulse: rd_data updated this cycle.
- `wipe_req`  in  1  request a bulk clear of all writable registers.
- `busy`  out  1  wipe in progress.
- `dbg`  out  `WIDTH`  combinational copy of register `DBG_SEL`.

## Operation
- Reset (`clear`=0, immediate, no clock needed):
  - Constants load: r0=0, r1=1, r2={1'b1, zeros} (MSB only, 16'h8000), r3=all ones (16'hFFFF), for as many as `NCONST` covers.
  - All other registers are 0.
  - `rd_data_*`=0, `rd_valid_*`=0, `busy`=0, FSM=IDLE.
- Constants: writes to index < `NCONST` are silently dropped. Constants are never wiped.
- Write: in IDLE, `wr_en`=1 with `wr_sel` >= `NCONST` stores `wr_data` at the edge.
- Read, each port independently:
  - In IDLE, `rd_en`=1 captures reg[sel] into `rd_data` at the edge, and `rd_valid` is 1 for the following cycle.
  - With `rd_en`=0, `rd_data` holds and `rd_valid`=0.
  - Both ports may select the same index.
- Read/write same index, same cycle: behaviour set by the macro (see Configuration).
- Wipe FSM, states IDLE and WIPE:
  - IDLE -> WIPE when `wipe_req`=1. The internal counter loads `NCONST`.
  - WIPE: each cycle, reg[counter] <= 0 and counter increments.
  - WIPE -> IDLE in the cycle in which counter = `DEPTH`-1 is cleared.
  - `busy`=1 throughout WIPE.
  - In WIPE, `wr_en`, `rd_en_*` and `wipe_req` are ignored: no writes occur, `rd_valid_*`=0 and `rd_data_*` hold.
  - `wipe_req` arriving in the same cycle as a write in IDLE: the write is performed and the wipe starts.
- Reset asserted mid-wipe: the wipe aborts, full reset values apply, and the FSM returns to IDLE.

## Timing
- Read latency 1 cycle: request at edge N, data and valid visible after edge N.
- Write visible to a read requested at edge N+1 or later.
- Wipe occupies exactly `DEPTH`-`NCONST` cycles (60 at default). `busy` rises after the accepting edge and falls after the last clearing edge.
- `dbg` is combinational from register storage: it reflects a write immediately after the write edge.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A read of index i in the same cycle as an accepted write of i returns `wr_data` (write-first forwarding).
  - Applies to each port independently.
  - Never applies to constant indices, because those writes are dropped.
- Macro undefined: the same-cycle read returns the old stored value (read-first), and the new value is readable from the next request.

## Test plan
- Reset: pulse `clear` low between edges. Then read r0..r3 and r10 -> 0x0000, 0x0001, 0x8000, 0xFFFF, 0x0000; `busy`=0.
- Constant protection: write 0x1234 to r1, then read r1 -> 0x0001. Write 0x1234 to r9, then read r9 on both ports -> 0x1234 on A and B, each `rd_valid` a single pulse.
- Same-cycle collision: write 0xBEEF to r20 while port A reads r20 (old value 0). The read returns 0xBEEF with `REGFILE_BYPASS_EN` and 0x0000 without; the next read returns 0xBEEF in both builds.
- Wipe:
  - Fill r4..r63 with nonzero data, then pulse `wipe_req`.
  - `busy` is high for exactly 60 cycles.
  - Reads issued during the wipe give `rd_valid`=0; a write of 0x5555 to r30 during the wipe is dropped.
  - Afterwards r4..r63 read 0 and r0..r3 keep their constants.
- Reset mid-wipe: assert `clear` 10 cycles into a wipe -> `busy` drops immediately and all registers hold reset values. A new `wipe_req` then completes normally.
- Debug tap: write 0xA5A5 to r8 -> `dbg`=0xA5A5 directly after the write edge, without issuing a read.
